execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
//   EX stage of the 5-stage MIPS pipeline; sits directly downstream of decode.
//   Consumes the ID/EX register, computes ALU result, zero flag, branch target and destination register.
//   Registers everything into EX/MEM for the memory stage.
//   Adds stall (hold) and flush (bubble) control for later hazard-unit integration.
// PARAMETERS
//   DATA_W  32  datapath width (only 32 is supported)
//   REG_AW  5   register-address width
// PORTS
//   clk                     in   1   rising-edge clock
//   rst                     in   1   asynchronous reset, active-high
//   stall                   in   1   hold EX/MEM contents this cycle
//   flush                   in   1   load a bubble (all-zero) into EX/MEM
//   id_ex_wb                in   2   {RegWrite, MemtoReg}, passed through
//   id_ex_mem               in   3   {Branch, MemRead, MemWrite}, passed through
//   id_ex_execute           in   4   {RegDst, ALUOp[1:0], ALUSrc}
//   id_ex_npc               in   32  PC+1 of this instruction
//   id_ex_readdat1          in   32  rs operand
//   id_ex_readdat2          in   32  rt operand
//   id_ex_sign_ext          in   32  sign-extended immediate; [5:0] = funct
//   id_ex_instr_bits_20_16  in   5   rt field
//   id_ex_instr_bits_15_11  in   5   rd field
//   ex_mem_wb               out  2   registered id_ex_wb
//   ex_mem_mem              out  3   registered id_ex_mem
//   ex_mem_add_result       out  32  branch target
//   ex_mem_zero             out  1   ALU result == 0
//   ex_mem_alu_result       out  32  ALU result
//   ex_mem_readdat2         out  32  registered rt operand (store data)
//   ex_mem_write_reg        out  5   destination register
// BEHAVIOUR
//   - Reset: every ex_mem_* output = 0 asynchronously; held until rst deasserts.
//   - Latency: 1 cycle; the ID/EX inputs present before edge N appear on EX/MEM after edge N.
//   - Per-edge priority: rst > flush (load all zeros) > stall (hold all) > normal load.
//   - ALU B operand = ALUSrc ? id_ex_sign_ext : id_ex_readdat2.
//   - ALU control:
//       ALUOp 00 -> ADD; 01 -> SUB.
//       ALUOp 10 -> by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
//       ALUOp 11, or any other funct -> NOP code 4'b1111, result 0.
//   - Control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NOP 1111.
//   - Arithmetic:
//       ADD/SUB: modulo 2^32; overflow ignored, no trap.
//       SLT: signed compare; result is 32'd1 or 32'd0.
//   - zero = (alu_result == 0), computed on the final 32-bit result.
//   - add_result = id_ex_npc + (id_ex_sign_ext << 2), modulo 2^32; the shifted-out bits are dropped.
//   - write_reg = RegDst ? bits_15_11 : bits_20_16.
//   - wb/mem/readdat2 are passed through unmodified (except on flush or reset).
//   - Reset released mid-stream: the first edge after release loads normally; no residual state.
//   - No internal FSM or memory beyond the EX/MEM register.
// STRUCTURE
//   - mips_pkg: ALU control codes, funct constants, ALUOp encodings, bit positions of the wb/mem/ex bundles.
//   - Sub-module alu: combinational; inputs a, b, ctrl[3:0]; outputs result and zero.
//   - This block contains only ALU control, the muxes, the branch adder and the EX/MEM register.
// TESTING
//   1. R-type ADD: execute=1100, funct=0x20, rd1=5, rd2=7, rd=2.
//      -> after 1 edge: alu=12, zero=0, write_reg=2.
//   2. BEQ: execute=0010, rd1=rd2=0x55, npc=2, sign_ext=8, mem=100.
//      -> alu=0, zero=1, add_result=0x22, mem=100.
//   3. LW: execute=0001, rd1=0x100, sign_ext=2, rt=2, wb=11.
//      -> alu=0x102, write_reg=2, wb=11.
//      SW: same operands, mem=001, rd2=0xABCD -> readdat2=0xABCD.
//   4. SLT signed: funct=0x2A, rd1=0xFFFFFFFF, rd2=1 -> alu=1.
//      Swapped operands -> alu=0, zero=1.
//      ADD 0xFFFFFFFF+1 -> alu=0, zero=1.
//   5. stall=1 for 2 cycles while inputs change -> outputs frozen.
//      flush=1 together with stall=1 -> all outputs 0 after the edge.
//   6. Assert rst asynchronously between edges with valid data loaded.
//      -> all outputs 0 immediately; first edge after release loads the current inputs.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALU control codes, funct values,
// ALUOp encodings and bit positions inside the ID/EX control bundles.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_NOP = 4'b1111
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_BRANCH   = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;
    localparam int EX_REGDST    = 3;
    localparam int EX_ALUOP_HI  = 2;
    localparam int EX_ALUOP_LO  = 1;
    localparam int EX_ALUSRC    = 0;

    // Anything not recognised (ALUOp 11 or an unknown funct) becomes NOP.
    function automatic alu_ctrl_e alu_control(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_ctrl_e ctrl;
        ctrl = ALU_NOP;
        case (alu_op)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_NOR: ctrl = ALU_NOR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default:   ctrl = ALU_NOP;
                endcase
            end
            default: ctrl = ALU_NOP;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; wraps on overflow and reports a zero flag on
// the final result.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_NOR: result = ~(a | b);
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/execute.sv
// EX stage of the 5-stage MIPS pipeline: ALU control, operand and
// destination muxes, branch-target adder and the EX/MEM pipeline register.
module execute
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        id_ex_wb,
    input  logic [2:0]        id_ex_mem,
    input  logic [3:0]        id_ex_execute,
    input  logic [DATA_W-1:0] id_ex_npc,
    input  logic [DATA_W-1:0] id_ex_readdat1,
    input  logic [DATA_W-1:0] id_ex_readdat2,
    input  logic [DATA_W-1:0] id_ex_sign_ext,
    input  logic [REG_AW-1:0] id_ex_instr_bits_20_16,
    input  logic [REG_AW-1:0] id_ex_instr_bits_15_11,
    output logic [1:0]        ex_mem_wb,
    output logic [2:0]        ex_mem_mem,
    output logic [DATA_W-1:0] ex_mem_add_result,
    output logic              ex_mem_zero,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] ex_mem_readdat2,
    output logic [REG_AW-1:0] ex_mem_write_reg
);

    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic [DATA_W-1:0] branch_target;
    logic [REG_AW-1:0] dest_reg;

    assign alu_ctrl = alu_control(id_ex_execute[EX_ALUOP_HI:EX_ALUOP_LO], id_ex_sign_ext[5:0]);
    assign alu_b    = id_ex_execute[EX_ALUSRC] ? id_ex_sign_ext : id_ex_readdat2;
    assign dest_reg = id_ex_execute[EX_REGDST] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;

    // Word offset: the two top immediate bits fall off the end of the shift.
    assign branch_target = id_ex_npc + {id_ex_sign_ext[DATA_W-3:0], 2'b00};

    alu u_alu (
        .a      (id_ex_readdat1),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_out),
        .zero   (alu_zero)
    );

    // Flush wins over stall so a bubble can be inserted into a held stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_wb         <= '0;
            ex_mem_mem        <= '0;
            ex_mem_add_result <= '0;
            ex_mem_zero       <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_readdat2   <= '0;
            ex_mem_write_reg  <= '0;
        end else if (flush) begin
            ex_mem_wb         <= '0;
            ex_mem_mem        <= '0;
            ex_mem_add_result <= '0;
            ex_mem_zero       <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_readdat2   <= '0;
            ex_mem_write_reg  <= '0;
        end else if (!stall) begin
            ex_mem_wb         <= id_ex_wb;
            ex_mem_mem        <= id_ex_mem;
            ex_mem_add_result <= branch_target;
            ex_mem_zero       <= alu_zero;
            ex_mem_alu_result <= alu_out;
            ex_mem_readdat2   <= id_ex_readdat2;
            ex_mem_write_reg  <= dest_reg;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the EX stage: ALU ops, branch target, muxes,
// stall/flush priority and asynchronous reset.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_execute;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_readdat1;
    logic [31:0] id_ex_readdat2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_instr_bits_20_16;
    logic [4:0]  id_ex_instr_bits_15_11;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_mem;
    logic [31:0] ex_mem_add_result;
    logic        ex_mem_zero;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_readdat2;
    logic [4:0]  ex_mem_write_reg;

    int total = 0;
    int bad   = 0;

    execute dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .flush                  (flush),
        .id_ex_wb               (id_ex_wb),
        .id_ex_mem              (id_ex_mem),
        .id_ex_execute          (id_ex_execute),
        .id_ex_npc              (id_ex_npc),
        .id_ex_readdat1         (id_ex_readdat1),
        .id_ex_readdat2         (id_ex_readdat2),
        .id_ex_sign_ext         (id_ex_sign_ext),
        .id_ex_instr_bits_20_16 (id_ex_instr_bits_20_16),
        .id_ex_instr_bits_15_11 (id_ex_instr_bits_15_11),
        .ex_mem_wb              (ex_mem_wb),
        .ex_mem_mem             (ex_mem_mem),
        .ex_mem_add_result      (ex_mem_add_result),
        .ex_mem_zero            (ex_mem_zero),
        .ex_mem_alu_result      (ex_mem_alu_result),
        .ex_mem_readdat2        (ex_mem_readdat2),
        .ex_mem_write_reg       (ex_mem_write_reg)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                         input logic [31:0] npc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
        id_ex_wb = wb;
        id_ex_mem = mem;
        id_ex_execute = ex;
        id_ex_npc = npc;
        id_ex_readdat1 = rd1;
        id_ex_readdat2 = rd2;
        id_ex_sign_ext = se;
        id_ex_instr_bits_20_16 = rt;
        id_ex_instr_bits_15_11 = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [106:0] all_outputs();
        return {ex_mem_wb, ex_mem_mem, ex_mem_add_result, ex_mem_zero,
                ex_mem_alu_result, ex_mem_readdat2, ex_mem_write_reg};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(2'b11, 3'b111, 4'b1100, 32'h10, 32'h5, 32'h7, 32'h20, 5'd3, 5'd4);
        #1;
        total++;
        if (all_outputs() !== 107'd0) begin
            bad++;
            $display("[TB] FAIL reset_async got=%h want=0", all_outputs());
        end
        tick();
        total++;
        if (all_outputs() !== 107'd0) begin
            bad++;
            $display("[TB] FAIL reset_held got=%h want=0", all_outputs());
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_rtype_add;
        drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'd7, 32'h20, 5'd9, 5'd2);
        tick();
        total++;
        if (ex_mem_alu_result !== 32'd12) begin
            bad++;
            $display("[TB] FAIL add_alu got=%h want=%h", ex_mem_alu_result, 32'd12);
        end
        total++;
        if (ex_mem_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL add_zero got=%b want=0", ex_mem_zero);
        end
        total++;
        if (ex_mem_write_reg !== 5'd2) begin
            bad++;
            $display("[TB] FAIL add_write_reg got=%0d want=2", ex_mem_write_reg);
        end
        total++;
        if ({ex_mem_wb, ex_mem_readdat2, ex_mem_add_result} !== {2'b10, 32'd7, 32'h80}) begin
            bad++;
            $display("[TB] FAIL add_pass got=%b/%h/%h want=10/7/80", ex_mem_wb, ex_mem_readdat2, ex_mem_add_result);
        end
    endtask

    task automatic test_branch;
        drive(2'b00, 3'b100, 4'b0010, 32'd2, 32'h55, 32'h55, 32'd8, 5'd1, 5'd6);
        tick();
        total++;
        if ({ex_mem_alu_result, ex_mem_zero} !== {32'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL beq_alu_zero got=%h/%b want=0/1", ex_mem_alu_result, ex_mem_zero);
        end
        total++;
        if (ex_mem_add_result !== 32'h22) begin
            bad++;
            $display("[TB] FAIL beq_target got=%h want=22", ex_mem_add_result);
        end
        total++;
        if (ex_mem_mem !== 3'b100) begin
            bad++;
            $display("[TB] FAIL beq_mem got=%b want=100", ex_mem_mem);
        end
        // Negative offset: npc 0x10 + (-1 << 2) = 0x0C
        drive(2'b00, 3'b100, 4'b0010, 32'h10, 32'h1, 32'h2, 32'hFFFF_FFFF, 5'd1, 5'd6);
        tick();
        total++;
        if ({ex_mem_add_result, ex_mem_zero} !== {32'h0C, 1'b0}) begin
            bad++;
            $display("[TB] FAIL beq_neg got=%h/%b want=c/0", ex_mem_add_result, ex_mem_zero);
        end
        drive(2'b00, 3'b100, 4'b0010, 32'h0, 32'h1, 32'h1, 32'h4000_0001, 5'd1, 5'd6);
        tick();
        total++;
        if (ex_mem_add_result !== 32'h4) begin
            bad++;
            $display("[TB] FAIL beq_shift_drop got=%h want=4", ex_mem_add_result);
        end
    endtask

    task automatic test_load_store;
        drive(2'b11, 3'b010, 4'b0001, 32'h0, 32'h100, 32'h0, 32'd2, 5'd2, 5'd7);
        tick();
        total++;
        if ({ex_mem_alu_result, ex_mem_write_reg, ex_mem_wb} !== {32'h102, 5'd2, 2'b11}) begin
            bad++;
            $display("[TB] FAIL lw got=%h/%0d/%b want=102/2/11", ex_mem_alu_result, ex_mem_write_reg, ex_mem_wb);
        end
        drive(2'b00, 3'b001, 4'b0001, 32'h0, 32'h100, 32'hABCD, 32'd2, 5'd2, 5'd7);
        tick();
        total++;
        if ({ex_mem_alu_result, ex_mem_readdat2, ex_mem_mem} !== {32'h102, 32'hABCD, 3'b001}) begin
            bad++;
            $display("[TB] FAIL sw got=%h/%h/%b want=102/abcd/001", ex_mem_alu_result, ex_mem_readdat2, ex_mem_mem);
        end
    endtask

    task automatic test_rtype_ops;
        logic [31:0] se_tab  [9] = '{32'h2A, 32'h2A, 32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h21, 32'h20};
        logic [3:0]  ex_tab  [9] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1110};
        logic [31:0] a_tab   [9] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'd5, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd3, 32'd3};
        logic [31:0] b_tab   [9] = '{32'h1, 32'hFFFF_FFFF, 32'h1, 32'd7, 32'hFF00, 32'hFF00, 32'hFF00, 32'd4, 32'd4};
        logic [31:0] exp_tab [9] = '{32'd1, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'hF000, 32'hFFF0, 32'hFFFF_000F, 32'd0, 32'd0};
        for (int i = 0; i < 9; i++) begin
            drive(2'b10, 3'b000, ex_tab[i], 32'h0, a_tab[i], b_tab[i], se_tab[i], 5'd8, 5'd9);
            tick();
            total++;
            if ({ex_mem_alu_result, ex_mem_zero} !== {exp_tab[i], exp_tab[i] == 32'd0}) begin
                bad++;
                $display("[TB] FAIL rtype_op%0d got=%h/%b want=%h/%b", i, ex_mem_alu_result, ex_mem_zero,
                         exp_tab[i], exp_tab[i] == 32'd0);
            end
        end
    endtask

    task automatic test_stall_flush;
        stall = 1'b0;
        flush = 1'b0;
        drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'd7, 32'h20, 5'd9, 5'd2);
        tick();
        stall = 1'b1;
        drive(2'b01, 3'b111, 4'b0001, 32'h40, 32'h300, 32'h99, 32'd4, 5'd11, 5'd12);
        tick();
        drive(2'b11, 3'b010, 4'b1100, 32'h44, 32'h1, 32'h2, 32'h22, 5'd13, 5'd14);
        tick();
        total++;
        if (all_outputs() !== {2'b10, 3'b000, 32'h80, 1'b0, 32'd12, 32'd7, 5'd2}) begin
            bad++;
            $display("[TB] FAIL stall_hold got=%h", all_outputs());
        end
        flush = 1'b1;
        tick();
        total++;
        if (all_outputs() !== 107'd0) begin
            bad++;
            $display("[TB] FAIL flush_over_stall got=%h want=0", all_outputs());
        end
        stall = 1'b0;
        flush = 1'b0;
        tick();
        total++;
        if ({ex_mem_alu_result, ex_mem_write_reg, ex_mem_wb} !== {32'hFFFF_FFFF, 5'd14, 2'b11}) begin
            bad++;
            $display("[TB] FAIL after_stall got=%h/%0d/%b want=ffffffff/14/11", ex_mem_alu_result, ex_mem_write_reg, ex_mem_wb);
        end
    endtask

    task automatic test_async_reset;
        drive(2'b11, 3'b011, 4'b0001, 32'h8, 32'h100, 32'h55, 32'd2, 5'd2, 5'd7);
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (all_outputs() !== 107'd0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h want=0", all_outputs());
        end
        tick();
        #2;
        rst = 1'b0;
        drive(2'b01, 3'b001, 4'b1100, 32'h4, 32'd9, 32'd4, 32'h22, 5'd3, 5'd5);
        tick();
        total++;
        if (all_outputs() !== {2'b01, 3'b001, 32'h8C, 1'b0, 32'd5, 32'd4, 5'd5}) begin
            bad++;
            $display("[TB] FAIL reset_release got=%h", all_outputs());
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_branch();
        test_load_store();
        test_rtype_ops();
        test_stall_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
